kp_voice_alloc: RTL and testbench
=================================

# kp_voice_alloc

Polyphonic voice allocator sitting between the MIDI/note front end and a bank of NUM_VOICES Karplus-Strong voice engines. It accepts note-on/note-off events over a valid/ready handshake and chooses a voice for each note-on: retrigger the same note, else the lowest free voice, else steal the oldest held voice. It then drives that voice's tuning, velocity, decay and a level trigger that meets the voice's debounce requirement. It also switches released voices to the release decay.

## Interface
- NUM_VOICES, 4: number of voice engines; 2..8.
- AGE_W, 16: per-voice age counter width.
- TRIG_HOLD, 8: a_clk cycles voice_trig is held high; must be ≥ 5 to pass the voice's debounce.
- a_clk  in  1  96 kHz audio clock.
- reset_n  in  1  reset, synchronous, active-low.
- note_valid  in  1  event present.
- note_ready  out  1  allocator can accept an event.
- note_on  in  1  1 = note-on, 0 = note-off.
- note_num  in  7  MIDI note number.
- note_vel  in  7  velocity.
- note_delay  in  10  delay_length for this note, pre-computed upstream.
- sustain_decay  in  12  decay applied while a note is held.
- release_decay  in  12  decay applied after note-off.
- voice_trig  out  NUM_VOICES  per-voice trigger level.
- voice_delay  out  NUM_VOICES*10  per-voice delay_length; voice i is at [10i+9:10i].
- voice_vel  out  NUM_VOICES*7  per-voice velocity.
- voice_decay  out  NUM_VOICES*12  per-voice decay.
- voice_held  out  NUM_VOICES  voice has a note held.
- note_dropped  out  1  one-cycle pulse when a note-on is discarded.

## Operation
- FSM states: IDLE, SEARCH, ISSUE.
  - IDLE: note_ready=1. On note_valid&note_ready, latch the event and go to SEARCH.
  - SEARCH: note_ready=0. Compute the target voice in one cycle, then go to ISSUE.
  - ISSUE: note_ready=0. Update the target voice's registers, then return to IDLE.
- A note-on with note_vel==0 is treated as a note-off.
- Per-voice state:
  - held bit, note register (7 bits).
  - age counter: cleared on assign; +1 per a_clk while held; saturates at all-ones.
  - trig counter (0..2*TRIG_HOLD).
- A voice is "busy" while its trig counter is non-zero.
- Note-on target, first match wins:
  1. a held voice with the same note (retrigger);
  2. the lowest-index non-held, non-busy voice;
  3. steal the held, non-busy voice with the largest age, ties to lowest index;
  4. none: drop the note.
- If the rule-1 voice is busy, the note is dropped and not retargeted.
- On assign:
  - voice_delay ← note_delay, voice_vel ← note_vel, voice_decay ← sustain_decay.
  - held ← 1, note ← note_num, age ← 0, trig counter ← 2*TRIG_HOLD.
- voice_trig[i] = 1 while trig counter > TRIG_HOLD. The counter decrements every cycle to 0, which guarantees ≥ TRIG_HOLD low cycles before any retrigger.
- Note-off:
  - Every held voice with a matching note: held ← 0, voice_decay ← release_decay.
  - voice_delay and voice_vel are unchanged so the string rings out.
  - No match: the event is ignored.
- sustain_decay and release_decay are sampled only at ISSUE, never continuously.

## Timing
- Reset values:
  - all voice_* outputs 0; voice_held 0; note_dropped 0.
  - note_ready 0 while reset_n=0, 1 on the first cycle after release.
  - all ages and trig counters 0; FSM in IDLE.
- Accept at edge T (IDLE, valid&ready). SEARCH occupies T+1. Register updates land at T+2 and are visible in cycle T+2.
  - voice_trig rises at T+2 and stays high TRIG_HOLD cycles.
  - note_dropped pulses in cycle T+2.
- Throughput: one event per 3 cycles. note_ready is low in SEARCH and ISSUE.
- Handshake rules:
  - note_valid may be held; the upstream must keep note_* stable until the accept cycle.
  - Events are never lost while note_ready=0.
- reset_n low mid-operation: next edge forces reset values. The latched event is discarded and any trig in progress is cut.
- Age counters and trig counters run in every FSM state.

## Configuration
- KP_ALLOC_STEAL_EN defined: rule 3 (oldest-voice steal) is active.
- Not defined: rule 3 is removed. When no free non-busy voice exists, a note-on is accepted, discarded, and pulses note_dropped. Note-off behaviour is unchanged.

## Test plan
- Post-reset, note-on note 60, vel 100, delay 366 → voice 0 gets delay 366, vel 100, decay=sustain_decay; voice_trig[0] high cycles T+2..T+9 (TRIG_HOLD=8); voice_held=0001.
- Four note-ons (60, 62, 64, 65) spaced 40 cycles → voices 0..3; a fifth note 67 steals voice 0 (oldest, with steal enabled); with KP_ALLOC_STEAL_EN undefined → note_dropped=1, no voice changes.
- Note-off note 62 → voice 1 held=0, decay=release_decay, delay/vel unchanged; next note-on takes voice 1 (lowest free).
- Note-on 60 vel 0 → same as note-off 60; repeated note-on 60 after 20 cycles → retriggers voice 0 only; note-on 60 again within 16 cycles → dropped (busy).
- note_valid held high with 3 queued events → each accepted exactly once, 3 cycles apart; note_ready low in SEARCH/ISSUE.
- reset_n low during SEARCH → event discarded, all outputs 0 next cycle, note_ready=1 the cycle after reset_n returns high.

Source files
------------

// File: rtl/kp_voice_alloc.sv
// kp_voice_alloc: note-on/off allocator driving a bank of Karplus-Strong voices.
// Define KP_ALLOC_STEAL_EN to let a note-on steal the oldest held voice when none is free.
module kp_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 16,
    parameter int TRIG_HOLD  = 8
) (
    input  logic                     a_clk,
    input  logic                     reset_n,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic                     note_on,
    input  logic [6:0]               note_num,
    input  logic [6:0]               note_vel,
    input  logic [9:0]               note_delay,
    input  logic [11:0]              sustain_decay,
    input  logic [11:0]              release_decay,
    output logic [NUM_VOICES-1:0]    voice_trig,
    output logic [NUM_VOICES*10-1:0] voice_delay,
    output logic [NUM_VOICES*7-1:0]  voice_vel,
    output logic [NUM_VOICES*12-1:0] voice_decay,
    output logic [NUM_VOICES-1:0]    voice_held,
    output logic                     note_dropped
);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int TRIG_W = $clog2(2 * TRIG_HOLD + 1);
    localparam logic [TRIG_W-1:0] TRIG_MAX = TRIG_W'(2 * TRIG_HOLD);
    localparam logic [TRIG_W-1:0] TRIG_THR = TRIG_W'(TRIG_HOLD);

    typedef enum logic [1:0] {IDLE, SEARCH, ISSUE} state_t;

    state_t                            state_q, state_d;
    logic                              ev_on_q, ev_on_d;
    logic [6:0]                        ev_num_q, ev_num_d, ev_vel_q, ev_vel_d;
    logic [9:0]                        ev_delay_q, ev_delay_d;
    logic [IDX_W-1:0]                  tgt_q, tgt_d;
    logic                              hit_q, hit_d;
    logic                              dropped_q, dropped_d;
    logic [NUM_VOICES-1:0]             held_q, held_d;
    logic [NUM_VOICES-1:0][6:0]        note_q, note_d, vel_q, vel_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]  age_q, age_d;
    logic [NUM_VOICES-1:0][TRIG_W-1:0] trig_q, trig_d;
    logic [NUM_VOICES-1:0][9:0]        delay_q, delay_d;
    logic [NUM_VOICES-1:0][11:0]       decay_q, decay_d;

    logic [NUM_VOICES-1:0] busy;
    logic                  rt_hit, fr_hit, sel_hit;
    logic [IDX_W-1:0]      rt_idx, fr_idx, sel_idx;
`ifdef KP_ALLOC_STEAL_EN
    logic                  st_hit;
    logic [IDX_W-1:0]      st_idx;
    logic [AGE_W-1:0]      st_age;
`endif

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        busy   = '0;
        rt_hit = 1'b0;
        rt_idx = '0;
        fr_hit = 1'b0;
        fr_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            busy[i] = trig_q[i] != '0;
            if (held_q[i] && note_q[i] == ev_num_q) begin
                rt_hit = 1'b1;
                rt_idx = IDX_W'(i);
            end
            if (!held_q[i] && !busy[i]) begin
                fr_hit = 1'b1;
                fr_idx = IDX_W'(i);
            end
        end
`ifdef KP_ALLOC_STEAL_EN
        st_hit = 1'b0;
        st_idx = '0;
        st_age = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (held_q[i] && !busy[i] && (!st_hit || age_q[i] > st_age)) begin
                st_hit = 1'b1;
                st_idx = IDX_W'(i);
                st_age = age_q[i];
            end
        end
        sel_hit = rt_hit ? !busy[rt_idx] : (fr_hit || st_hit);
        sel_idx = rt_hit ? rt_idx : (fr_hit ? fr_idx : st_idx);
`else
        sel_hit = rt_hit ? !busy[rt_idx] : fr_hit;
        sel_idx = rt_hit ? rt_idx : fr_idx;
`endif
    end

    always_comb begin
        state_d    = state_q;
        ev_on_d    = ev_on_q;
        ev_num_d   = ev_num_q;
        ev_vel_d   = ev_vel_q;
        ev_delay_d = ev_delay_q;
        tgt_d      = tgt_q;
        hit_d      = hit_q;
        dropped_d  = 1'b0;
        held_d     = held_q;
        note_d     = note_q;
        vel_d      = vel_q;
        delay_d    = delay_q;
        decay_d    = decay_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            age_d[i]  = (held_q[i] && age_q[i] != '1) ? age_q[i] + AGE_W'(1) : age_q[i];
            trig_d[i] = busy[i] ? trig_q[i] - TRIG_W'(1) : '0;
        end
        if (state_q == IDLE && note_valid && note_ready) begin
            ev_on_d    = note_on;
            ev_num_d   = note_num;
            ev_vel_d   = note_vel;
            ev_delay_d = note_delay;
            state_d    = SEARCH;
        end
        if (state_q == SEARCH) begin
            hit_d   = sel_hit;
            tgt_d   = sel_idx;
            state_d = ISSUE;
        end
        if (state_q == ISSUE) begin
            state_d = IDLE;
            if (ev_on_q && ev_vel_q != '0) begin
                if (hit_q) begin
                    delay_d[tgt_q] = ev_delay_q;
                    vel_d[tgt_q]   = ev_vel_q;
                    decay_d[tgt_q] = sustain_decay;
                    held_d[tgt_q]  = 1'b1;
                    note_d[tgt_q]  = ev_num_q;
                    age_d[tgt_q]   = '0;
                    trig_d[tgt_q]  = TRIG_MAX;
                end else begin
                    dropped_d = 1'b1;
                end
            end else begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (held_q[i] && note_q[i] == ev_num_q) begin
                        held_d[i]  = 1'b0;
                        decay_d[i] = release_decay;
                    end
                end
            end
        end
    end

    always_ff @(posedge a_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ev_on_q    <= 1'b0;
            ev_num_q   <= '0;
            ev_vel_q   <= '0;
            ev_delay_q <= '0;
            tgt_q      <= '0;
            hit_q      <= 1'b0;
            dropped_q  <= 1'b0;
            held_q     <= '0;
            note_q     <= '0;
            vel_q      <= '0;
            age_q      <= '0;
            trig_q     <= '0;
            delay_q    <= '0;
            decay_q    <= '0;
        end else begin
            state_q    <= state_d;
            ev_on_q    <= ev_on_d;
            ev_num_q   <= ev_num_d;
            ev_vel_q   <= ev_vel_d;
            ev_delay_q <= ev_delay_d;
            tgt_q      <= tgt_d;
            hit_q      <= hit_d;
            dropped_q  <= dropped_d;
            held_q     <= held_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            age_q      <= age_d;
            trig_q     <= trig_d;
            delay_q    <= delay_d;
            decay_q    <= decay_d;
        end
    end

    always_comb begin
        voice_trig = '0;
        for (int i = 0; i < NUM_VOICES; i++) voice_trig[i] = trig_q[i] > TRIG_THR;
    end

    assign note_ready   = reset_n && state_q == IDLE;
    assign voice_delay  = delay_q;
    assign voice_vel    = vel_q;
    assign voice_decay  = decay_q;
    assign voice_held   = held_q;
    assign note_dropped = dropped_q;
endmodule

// File: tb/tb_kp_voice_alloc.sv
// tb_kp_voice_alloc: directed self-checking bench for kp_voice_alloc (4 voices, TRIG_HOLD=8).
module tb_kp_voice_alloc;
    localparam logic [11:0] SUS = 12'h321;
    localparam logic [11:0] REL = 12'h0AB;

    logic        a_clk = 1'b0;
    logic        reset_n;
    logic        note_valid, note_ready, note_on;
    logic [6:0]  note_num, note_vel;
    logic [9:0]  note_delay;
    logic [11:0] sustain_decay, release_decay;
    logic [3:0]  voice_trig, voice_held;
    logic [39:0] voice_delay;
    logic [27:0] voice_vel;
    logic [47:0] voice_decay;
    logic        note_dropped;
    int          tests = 0;
    int          fails = 0;

    kp_voice_alloc #(.NUM_VOICES(4), .AGE_W(16), .TRIG_HOLD(8)) dut (
        .a_clk(a_clk), .reset_n(reset_n), .note_valid(note_valid), .note_ready(note_ready),
        .note_on(note_on), .note_num(note_num), .note_vel(note_vel), .note_delay(note_delay),
        .sustain_decay(sustain_decay), .release_decay(release_decay), .voice_trig(voice_trig),
        .voice_delay(voice_delay), .voice_vel(voice_vel), .voice_decay(voice_decay),
        .voice_held(voice_held), .note_dropped(note_dropped)
    );

    always #5 a_clk = ~a_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge a_clk);
        #1;
    endtask

    // Returns 1 time unit after the accept edge (FSM then in SEARCH).
    task automatic send(input logic on, input logic [6:0] num, input logic [6:0] vel, input logic [9:0] dly);
        int n = 0;
        @(negedge a_clk);
        while (!note_ready && n < 20) begin
            n++;
            @(negedge a_clk);
        end
        check("send_ready", note_ready, 1);
        note_valid = 1'b1;
        note_on    = on;
        note_num   = num;
        note_vel   = vel;
        note_delay = dly;
        @(posedge a_clk);
        #1;
        note_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        note_valid = 1'b0;
        note_on = 1'b0;
        note_num = '0;
        note_vel = '0;
        note_delay = '0;
        sustain_decay = SUS;
        release_decay = REL;
        cyc(3);
        check("rst_ready_low", note_ready, 0);
        @(negedge a_clk);
        reset_n = 1'b1;
        #1;
        check("rst_ready_high", note_ready, 1);
        check("rst_held", voice_held, 0);
        check("rst_trig", voice_trig, 0);
        check("rst_delay", voice_delay, 0);
        check("rst_vel", voice_vel, 0);
        check("rst_decay", voice_decay, 0);
        check("rst_drop", note_dropped, 0);

        send(1, 60, 100, 366);
        check("search_ready", note_ready, 0);
        check("search_trig", voice_trig, 0);
        cyc(1);
        check("issue_ready", note_ready, 0);
        check("issue_held", voice_held, 0);
        cyc(1);
        check("v0_trig", voice_trig, 4'b0001);
        check("v0_delay", voice_delay[9:0], 366);
        check("v0_vel", voice_vel[6:0], 100);
        check("v0_decay", voice_decay[11:0], SUS);
        check("v0_held", voice_held, 4'b0001);
        check("idle_ready", note_ready, 1);
        cyc(7);
        check("v0_trig_last", voice_trig, 4'b0001);
        cyc(1);
        check("v0_trig_end", voice_trig, 4'b0000);

        cyc(30);
        send(1, 62, 90, 300);
        cyc(2);
        check("v1_delay", voice_delay[19:10], 300);
        check("v1_held", voice_held, 4'b0011);
        cyc(40);
        send(1, 64, 80, 280);
        cyc(2);
        check("v2_delay", voice_delay[29:20], 280);
        check("v2_held", voice_held, 4'b0111);
        cyc(40);
        send(1, 65, 70, 250);
        cyc(2);
        check("v3_delay", voice_delay[39:30], 250);
        check("v3_vel", voice_vel[27:21], 70);
        check("v3_held", voice_held, 4'b1111);
        cyc(20);

        send(1, 67, 60, 200);
        cyc(2);
`ifdef KP_ALLOC_STEAL_EN
        check("steal_delay", voice_delay[9:0], 200);
        check("steal_vel", voice_vel[6:0], 60);
        check("steal_trig", voice_trig, 4'b0001);
        check("steal_drop", note_dropped, 0);
`else
        check("full_drop", note_dropped, 1);
        check("full_delay", voice_delay[9:0], 366);
        check("full_vel", voice_vel[6:0], 100);
        check("full_trig", voice_trig, 4'b0000);
`endif
        check("full_held", voice_held, 4'b1111);
        cyc(1);
        check("drop_pulse_end", note_dropped, 0);

        send(0, 62, 0, 0);
        cyc(2);
        check("off_held", voice_held, 4'b1101);
        check("off_decay", voice_decay[23:12], REL);
        check("off_delay", voice_delay[19:10], 300);
        check("off_vel", voice_vel[13:7], 90);
        check("off_other_decay", voice_decay[35:24], SUS);
        send(1, 69, 50, 180);
        cyc(2);
        check("refill_delay", voice_delay[19:10], 180);
        check("refill_decay", voice_decay[23:12], SUS);
        check("refill_held", voice_held, 4'b1111);

        send(0, 60, 0, 0);
        send(0, 67, 0, 0);
        send(0, 64, 0, 0);
        send(0, 65, 0, 0);
        send(0, 69, 0, 0);
        cyc(2);
        check("clear_held", voice_held, 4'b0000);
        check("clear_decay", voice_decay, {4{REL}});

        cyc(20);
        send(1, 60, 100, 366);
        cyc(2);
        check("n60_held", voice_held, 4'b0001);
        cyc(20);
        send(1, 60, 110, 370);
        cyc(2);
        check("retrig_delay", voice_delay[9:0], 370);
        check("retrig_held", voice_held, 4'b0001);
        check("retrig_trig", voice_trig, 4'b0001);
        check("retrig_drop", note_dropped, 0);
        send(1, 60, 120, 400);
        cyc(2);
        check("busy_drop", note_dropped, 1);
        check("busy_delay", voice_delay[9:0], 370);
        check("busy_vel", voice_vel[6:0], 110);
        check("busy_held", voice_held, 4'b0001);
        send(1, 60, 0, 999);
        cyc(2);
        check("vel0_held", voice_held, 4'b0000);
        check("vel0_decay", voice_decay[11:0], REL);
        check("vel0_delay", voice_delay[9:0], 370);
        check("vel0_drop", note_dropped, 0);

        cyc(20);
        note_valid = 1'b1;
        note_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            note_num   = 7'(70 + k);
            note_vel   = 7'(11 + k);
            note_delay = 10'(101 + k);
            n = 0;
            @(negedge a_clk);
            while (!note_ready && n < 10) begin
                n++;
                @(negedge a_clk);
            end
            if (k > 0) check("queue_gap", n, 2);
            @(posedge a_clk);
            #1;
        end
        note_valid = 1'b0;
        cyc(4);
        check("queue_held", voice_held, 4'b0111);
        check("queue_delay", voice_delay[29:0], {10'd103, 10'd102, 10'd101});
        check("queue_vel", voice_vel[20:0], {7'd13, 7'd12, 7'd11});

        cyc(20);
        send(1, 73, 33, 77);
        reset_n = 1'b0;
        cyc(1);
        check("mid_rst_held", voice_held, 0);
        check("mid_rst_delay", voice_delay, 0);
        check("mid_rst_vel", voice_vel, 0);
        check("mid_rst_decay", voice_decay, 0);
        check("mid_rst_ready", note_ready, 0);
        @(negedge a_clk);
        reset_n = 1'b1;
        cyc(1);
        check("post_rst_ready", note_ready, 1);
        cyc(2);
        check("post_rst_held", voice_held, 0);
        check("post_rst_trig", voice_trig, 0);
        check("post_rst_drop", note_dropped, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
